// File: rtl/user_id_reader_if.sv
// Request/response bus of the user/project ID block.
// master drives requests, slave returns the registered read data.
interface user_id_reader_if #(
  parameter int ID_WIDTH = 32,
  parameter int AW       = 3
);
  logic                req_valid;
  logic [AW-1:0]       req_addr;
  logic                req_ready;
  logic                rsp_valid;
  logic [ID_WIDTH-1:0] rsp_data;
  logic                rsp_err;
  logic                rsp_ready;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/user_id_reader.sv
// Hard-wired ID words with XOR checksum, read over a registered
// request/response port and a self-timed serial shift-out port.
module user_id_reader #(
  parameter int ID_WIDTH  = 32,
  parameter int NUM_WORDS = 4,
  parameter logic [NUM_WORDS*ID_WIDTH-1:0] ID_VALUES = '0,
  parameter int SER_DIV   = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  user_id_reader_if.slave     bus,
  input  logic                ser_start,
  output logic                ser_busy,
  output logic                ser_clk,
  output logic                ser_data,
  output logic [ID_WIDTH-1:0] mask_rev
);
  localparam int AW = $clog2(NUM_WORDS + 1);
  localparam int BW = $clog2(ID_WIDTH);
  localparam int DW = $clog2(SER_DIV + 1);
  localparam int NW = 2 ** AW;

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_DONE
  } state_t;

  logic [ID_WIDTH-1:0] chk_c;
  logic [ID_WIDTH-1:0] chk_q;
  logic [ID_WIDTH-1:0] words [NW];

  always_comb begin
    chk_c = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      chk_c ^= ID_VALUES[k*ID_WIDTH +: ID_WIDTH];
  end

  // Pad the table to a power of two so out-of-range reads index a zero word.
  for (genvar k = 0; k < NW; k++) begin : g_word
    if (k < NUM_WORDS) begin : g_id
      assign words[k] = ID_VALUES[k*ID_WIDTH +: ID_WIDTH];
    end else if (k == NUM_WORDS) begin : g_chk
      assign words[k] = chk_q;
    end else begin : g_pad
      assign words[k] = '0;
    end
  end

  assign mask_rev = ID_VALUES[ID_WIDTH-1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) chk_q <= '0;
    else          chk_q <= chk_c;
  end

  logic                up_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [ID_WIDTH-1:0] rsp_data_q;
  logic                acc;

  assign bus.req_ready = up_q & ~rsp_valid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign acc = bus.req_valid & bus.req_ready;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      up_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      up_q <= 1'b1;
      if (acc) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= words[bus.req_addr];
        rsp_err_q   <= bus.req_addr > AW'(NUM_WORDS);
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] sh_q;
  logic [BW-1:0]       bit_cnt_q;
  logic [AW-1:0]       word_idx_q;
  logic [DW-1:0]       div_q;
  logic                bit_end;
  logic                word_end;
  logic                last_word;

  assign bit_end   = div_q == DW'(SER_DIV - 1);
  assign word_end  = bit_end & (bit_cnt_q == '0);
  assign last_word = word_idx_q == AW'(NUM_WORDS);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ser_start) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (word_end && last_word) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ser_busy = 1'b0;
    ser_clk  = 1'b0;
    ser_data = 1'b0;
    unique case (state_q)
      S_LOAD:  ser_busy = 1'b1;
      S_SHIFT: begin
        ser_busy = 1'b1;
        ser_clk  = bit_end;
        ser_data = sh_q[ID_WIDTH-1];
      end
      default: ;
    endcase
  end

  // Word index NUM_WORDS selects the checksum, so it streams like any word.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      div_q      <= '0;
    end else if (state_q == S_LOAD) begin
      sh_q       <= words[0];
      bit_cnt_q  <= BW'(ID_WIDTH - 1);
      word_idx_q <= '0;
      div_q      <= '0;
    end else if (state_q == S_SHIFT) begin
      if (!bit_end) begin
        div_q <= div_q + DW'(1);
      end else begin
        div_q <= '0;
        if (bit_cnt_q != '0) begin
          sh_q      <= sh_q << 1;
          bit_cnt_q <= bit_cnt_q - BW'(1);
        end else if (!last_word) begin
          sh_q       <= words[word_idx_q + AW'(1)];
          bit_cnt_q  <= BW'(ID_WIDTH - 1);
          word_idx_q <= word_idx_q + AW'(1);
        end
      end
    end
  end
endmodule
